// File: rtl/alu_share_arbiter.sv
// Round-robin arbiter time-sharing one ALU among NUM_REQ valid/ready requesters.
// Optional: define ALU_ARB_OPCHK_EN to flag illegal opcodes on the response channel.
module alu_share_arbiter #(
   parameter int NUM_REQ = 4,
   parameter int WIDTH   = 32,
   parameter int ID_W    = $clog2(NUM_REQ)
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic [NUM_REQ-1:0]       req_valid,
   output logic [NUM_REQ-1:0]       req_ready,
   input  logic [3*NUM_REQ-1:0]     req_op,
   input  logic [WIDTH*NUM_REQ-1:0] req_src1,
   input  logic [WIDTH*NUM_REQ-1:0] req_src2,
   output logic [2:0]               alu_ctrl,
   output logic [WIDTH-1:0]         alu_src1,
   output logic [WIDTH-1:0]         alu_src2,
   input  logic [WIDTH-1:0]         alu_result,
   input  logic                     alu_z,
   output logic                     resp_valid,
   input  logic                     resp_ready,
   output logic [ID_W-1:0]          resp_id,
   output logic [WIDTH-1:0]         resp_result,
   output logic                     resp_z,
   output logic                     resp_err
);

   typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;

   state_t            r_state;
   logic [ID_W-1:0]   r_rr_ptr;
   logic [2:0]        r_op;
   logic [WIDTH-1:0]  r_a;
   logic [WIDTH-1:0]  r_b;
   logic [ID_W-1:0]   r_id;
   logic [ID_W-1:0]   r_resp_id;
   logic [WIDTH-1:0]  r_res;
   logic              r_z;
   logic              r_err;

   logic [2:0]        w_op   [NUM_REQ];
   logic [WIDTH-1:0]  w_src1 [NUM_REQ];
   logic [WIDTH-1:0]  w_src2 [NUM_REQ];
   logic              w_grant_vld;
   logic [ID_W-1:0]   w_grant_idx;
   logic [2:0]        w_gop;
   logic              w_illegal;

   genvar gi;
   generate
      for (gi = 0; gi < NUM_REQ; gi++) begin : g_unpack
         assign w_op[gi]   = req_op[3*gi +: 3];
         assign w_src1[gi] = req_src1[WIDTH*gi +: WIDTH];
         assign w_src2[gi] = req_src2[WIDTH*gi +: WIDTH];
      end
   endgenerate

   // Scan from the farthest candidate back to rr_ptr so the nearest valid wins.
   always_comb begin
      w_grant_vld = 1'b0;
      w_grant_idx = '0;
      for (int k = NUM_REQ - 1; k >= 0; k--) begin
         int j;
         j = int'(r_rr_ptr) + k;
         if (j >= NUM_REQ) j = j - NUM_REQ;
         if (req_valid[j]) begin
            w_grant_vld = 1'b1;
            w_grant_idx = ID_W'(j);
         end
      end
   end

   assign w_gop = w_op[w_grant_idx];

`ifdef ALU_ARB_OPCHK_EN
   assign w_illegal = (w_gop == 3'b100) || (w_gop == 3'b110) || (w_gop == 3'b111);
`else
   assign w_illegal = 1'b0;
`endif

   assign req_ready = (r_state == IDLE && !rst && w_grant_vld)
                      ? (NUM_REQ'(1) << w_grant_idx) : '0;

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state   <= IDLE;
         r_rr_ptr  <= '0;
         r_op      <= 3'b000;
         r_a       <= '0;
         r_b       <= '0;
         r_id      <= '0;
         r_resp_id <= '0;
         r_res     <= '0;
         r_z       <= 1'b0;
         r_err     <= 1'b0;
      end else begin
         case (r_state)
            IDLE: if (w_grant_vld) begin
               r_op    <= w_illegal ? 3'b000 : w_gop;
               r_err   <= w_illegal;
               r_a     <= w_src1[w_grant_idx];
               r_b     <= w_src2[w_grant_idx];
               r_id    <= w_grant_idx;
               r_state <= EXEC;
            end
            EXEC: begin
               // Illegal ops still run as an add, but their result is masked to 0 / Z=1.
               r_res     <= r_err ? '0 : alu_result;
               r_z       <= r_err ? 1'b1 : alu_z;
               r_resp_id <= r_id;
               r_rr_ptr  <= (r_id == ID_W'(NUM_REQ - 1)) ? '0 : r_id + 1'b1;
               r_state   <= RESP;
            end
            RESP: if (resp_ready) r_state <= IDLE;
            default: r_state <= IDLE;
         endcase
      end
   end

   assign alu_ctrl    = r_op;
   assign alu_src1    = r_a;
   assign alu_src2    = r_b;
   assign resp_valid  = (r_state == RESP);
   assign resp_id     = r_resp_id;
   assign resp_result = r_res;
   assign resp_z      = r_z;
   assign resp_err    = (r_state == RESP) && r_err;

endmodule

// File: doc/alu_share_arbiter.md
Name: alu_share_arbiter

Overview:
Time-shares one `alu` instance among NUM_REQ requesters using per-requester valid/ready handshakes and round-robin arbitration. It latches the granted requester's opcode and operands, drives them to the ALU, captures ALU_result and Z, and returns them on a shared response channel tagged with the requester id. It sits between the ALU and its clients, for example address generation, branch compare and a multi-cycle helper, in multi-cycle variants of the core.

Parameters:
NUM_REQ, 4, number of requesters (2..8)
WIDTH, 32, operand and result width; must match the ALU datapath
ID_W, $clog2(NUM_REQ), width of resp_id

Ports:
clk  input  1  single clock, rising edge
rst  input  1  reset, synchronous, active-high
req_valid  input  NUM_REQ  per-requester request valid
req_ready  output  NUM_REQ  per-requester grant/accept, one-hot or zero
req_op  input  3*NUM_REQ  ALU opcode per requester, slice i = [3i+2:3i]
req_src1  input  WIDTH*NUM_REQ  operand 1 per requester
req_src2  input  WIDTH*NUM_REQ  operand 2 per requester
alu_ctrl  output  3  to ALU ALU_control
alu_src1  output  WIDTH  to ALU src1
alu_src2  output  WIDTH  to ALU src2
alu_result  input  WIDTH  from ALU ALU_result
alu_z  input  1  from ALU Z
resp_valid  output  1  response valid
resp_ready  input  1  response consumer ready
resp_id  output  ID_W  index of the requester being answered
resp_result  output  WIDTH  captured ALU result
resp_z  output  1  captured zero flag
resp_err  output  1  illegal-opcode flag (see Optional Feature)

Behaviour:
- Opcodes: add 000, sub 001, and 010, or 011, slt 101 (signed). All other codes are illegal.
- FSM states: IDLE, EXEC, RESP. All state is updated on the rising edge of clk.
- Reset (rst=1 at a clock edge) sets:
  - state=IDLE, rr_ptr=0;
  - op_q=000, a_q=0, b_q=0, id_q=0;
  - res_q=0, z_q=0, err_q=0.
- Outputs while and after reset: resp_valid=0, req_ready=0, alu_ctrl=000, alu_src1=0, alu_src2=0, resp_id=0, resp_result=0, resp_z=0, resp_err=0.
- IDLE, when any req_valid is high:
  - grant g = first i with req_valid[i], searching i = rr_ptr, rr_ptr+1, ... modulo NUM_REQ;
  - req_ready[g]=1 combinationally in that cycle only; all other req_ready bits are 0;
  - at the clock edge, latch op_q/a_q/b_q from slice g and set id_q=g; next state EXEC.
- IDLE, when no req_valid is high: stay in IDLE; req_ready=0.
- A transfer occurs only when req_valid[i] and req_ready[i] are both 1. A requester may deassert valid before it is granted. Operands are sampled only in the grant cycle.
- alu_ctrl, alu_src1 and alu_src2 are driven directly from op_q, a_q and b_q in every state, so no combinational path runs from req_* to the ALU.
- EXEC (exactly 1 cycle):
  - capture res_q=alu_result and z_q=alu_z;
  - rr_ptr = (id_q+1) mod NUM_REQ, wrapping NUM_REQ-1 to 0;
  - next state RESP.
- RESP:
  - resp_valid=1; resp_id=id_q; resp_result=res_q; resp_z=z_q; resp_err=err_q;
  - these values hold stable until resp_ready=1 is sampled, then next state is IDLE;
  - req_ready=0 throughout RESP.
- resp_valid is 0 in IDLE and EXEC. resp_result, resp_z and resp_id keep their last values outside RESP.
- Latency: grant in cycle T gives resp_valid in cycle T+2. Minimum issue interval is 3 cycles.
- Fairness: with all requesters continuously valid, grants rotate 0,1,...,NUM_REQ-1,0. No requester waits more than NUM_REQ grants.
- Reset mid-operation: any in-flight request in EXEC or RESP is dropped and no response is produced. The dropped requester must re-request.
- rst and req_valid asserted in the same cycle: reset wins and no grant is issued.

Optional Feature:
- Macro: ALU_ARB_OPCHK_EN.
- Defined:
  - at grant, err_q = 1 if the granted opcode is illegal (100, 110, 111), else 0;
  - an illegal opcode is latched as op_q=000, so the ALU sees a harmless add of the operands;
  - in RESP, resp_err=1 and resp_result/resp_z are forced to 0/1.
- Undefined:
  - err_q is held at 0 and resp_err is tied to 0;
  - the opcode passes through unchanged, and the ALU's default gives result 0, Z=1.

Test Plan:
- Reset, then req0 add src1=5, src2=7 -> req_ready[0] in cycle T; at T+2 resp_valid=1, resp_id=0, resp_result=12, resp_z=0.
- req2 sub 9-9, then req1 slt 0xFFFFFFFF vs 1 -> first response id=2, result 0, z=1; second response id=1, result 1, z=0.
- All 4 req_valid held high with distinct operands, resp_ready=1 -> grant order 0,1,2,3,0; one grant every 3 cycles; each response id matches its grant.
- resp_ready low for 5 cycles in RESP while req1 is valid -> resp_valid and data stable, req_ready stays 0; grant to req1 occurs one cycle after resp_ready rises.
- rst asserted during EXEC of a req3 op -> no resp_valid afterward; all outputs return to reset values; rr_ptr=0, so the next simultaneous req0/req3 request grants 0.
- req0 op=3'b111, src1=4, src2=4 -> with ALU_ARB_OPCHK_EN: resp_err=1, resp_result=0, resp_z=1; without it: resp_err=0, resp_result=0, resp_z=1.
